// File: rtl/fetch_unit_pkg.sv
// Core-wide defines shared by fetch and decode: instruction width, reset PC,
// opcode constants and the fetch buffer entry layout.
package fetch_unit_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
        return {addr[ILEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; head is read combinationally,
// flush empties it and overrides any same-cycle push or pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wr_data,
    output fetch_entry_t                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word reads, buffers
// in-order responses and drops wrong-path responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      pc;
    logic [31:0]      resp_pc;
    logic [31:0]      target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             fire;
    logic             push;
    logic             pop;
    logic             drop_resp;
    logic             credit;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Credit uses registered occupancy only; a same-cycle pop frees nothing yet.
    assign credit         = (SUM_W'(outstanding) + SUM_W'(count)) < SUM_W'(DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && !full && credit;
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign target    = word_align(redirect_pc);
    assign drop_resp = imem_resp_valid && (drop_cnt != '0);
    assign push      = imem_resp_valid && !drop_resp && !redirect_valid;
    assign pop       = id_valid && id_ready && !redirect_valid;
    assign wr_entry  = '{pc: resp_pc, instr: imem_resp_data};

    assign id_valid = !empty;
    assign id_instr = empty ? '0 : head.instr;
    assign id_pc    = empty ? '0 : head.pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // On redirect every request still in flight belongs to the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            pc          <= target;
            resp_pc     <= target;
            outstanding <= outstanding - CNT_W'(imem_resp_valid);
            drop_cnt    <= outstanding - CNT_W'(imem_resp_valid);
        end else begin
            if (fire) pc      <= pc + 32'd4;
            if (push) resp_pc <= resp_pc + 32'd4;
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_resp_valid);
            if (drop_resp) drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (SUM_W'(outstanding) + SUM_W'(count)) <= SUM_W'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model and
// a decode-side monitor recording every accepted {pc, instr}.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        mem_hold;
    logic [31:0] pend_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] instr_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: responds the cycle after a fire unless held, in order, one per cycle.
    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
            if (!mem_hold && pend_q.size() > 0) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= word_of(pend_q.pop_front());
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && id_valid && id_ready && !redirect_valid) begin
            pc_q.push_back(id_pc);
            instr_q.push_back(id_instr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        mem_hold       = 1'b0;
        repeat (2) cycle();
        pc_q.delete();
        instr_q.delete();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values while rst is held
        rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        id_ready = 1'b0; mem_hold = 1'b0;
        repeat (2) cycle();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid",  32'(id_valid),       32'd0);
        check("rst_id_instr",  id_instr,            32'h0);
        check("rst_id_pc",     id_pc,               32'h0);

        // Sequential fetch with free-flowing memory and decode
        do_reset();
        check("seq_first_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (10) cycle();
        imem_req_ready = 1'b0;
        repeat (4) cycle();
        check("seq_n_ge4", 32'(pc_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq_pc%0d", i),    pc_q[i],    32'(i * 4));
            check($sformatf("seq_instr%0d", i), instr_q[i], 32'hDEAD_0000 | 32'(i * 4));
        end

        // Decode stall: two fires fill the buffer, then fetch stops
        do_reset();
        imem_req_ready = 1'b1;
        repeat (3) cycle();
        check("dstall_req_valid", 32'(imem_req_valid), 32'd0);
        check("dstall_id_valid",  32'(id_valid),       32'd1);
        check("dstall_id_pc",     id_pc,               32'h0);
        check("dstall_id_instr",  id_instr,            32'hDEAD_0000);
        cycle();
        check("dstall_id_pc_hold", id_pc, 32'h0);
        imem_req_ready = 1'b0; id_ready = 1'b1;
        repeat (4) cycle();
        check("dstall_n",      32'(pc_q.size()), 32'd2);
        check("dstall_pc0",    pc_q[0],          32'h0);
        check("dstall_pc1",    pc_q[1],          32'h4);
        check("dstall_instr1", instr_q[1],       32'hDEAD_0004);

        // Memory stall: request to 0x8 held for 5 cycles, fires when ready rises
        do_reset();
        imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (2) cycle();
        imem_req_ready = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mstall_valid%0d", i), 32'(imem_req_valid), 32'd1);
            check($sformatf("mstall_addr%0d", i),  imem_req_addr,       32'h8);
            cycle();
        end
        imem_req_ready = 1'b1;
        #1;
        check("mstall_rise_valid", 32'(imem_req_valid), 32'd1);
        cycle();
        check("mstall_next_addr", imem_req_addr, 32'hC);
        imem_req_ready = 1'b0;
        repeat (4) cycle();
        check("mstall_n",      32'(pc_q.size()), 32'd3);
        check("mstall_pc2",    pc_q[2],          32'h8);
        check("mstall_instr2", instr_q[2],       32'hDEAD_0008);

        // Redirect with two requests outstanding
        do_reset();
        mem_hold = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (2) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0; mem_hold = 1'b0;
        #1;
        check("redir_addr", imem_req_addr, 32'h100);
        repeat (3) cycle();
        imem_req_ready = 1'b0;
        repeat (3) cycle();
        check("redir_n",      32'(pc_q.size()), 32'd1);
        check("redir_pc0",    pc_q[0],          32'h100);
        check("redir_instr0", instr_q[0],       32'hDEAD_0100);

        // Collision: redirect, response and pop in one cycle
        do_reset();
        imem_req_ready = 1'b1;
        repeat (2) cycle();
        check("coll_pre_id_valid", 32'(id_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("coll_id_valid",  32'(id_valid),       32'd0);
        check("coll_req_valid", 32'(imem_req_valid), 32'd1);
        check("coll_addr",      imem_req_addr,       32'h200);
        check("coll_no_pop",    32'(pc_q.size()),    32'd0);
        cycle();
        imem_req_ready = 1'b0;
        repeat (3) cycle();
        check("coll_n",   32'(pc_q.size()), 32'd1);
        check("coll_pc0", pc_q[0],          32'h200);

        // Redirect to the top word; PC wraps to zero
        do_reset();
        imem_req_ready = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        #1;
        check("wrap_no_req", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("wrap_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_addr",  imem_req_addr,       32'hFFFF_FFFC);
        cycle();
        check("wrap_addr_next", imem_req_addr, 32'h0);
        imem_req_ready = 1'b0;
        repeat (3) cycle();
        check("wrap_pc0",    pc_q[0],    32'hFFFF_FFFC);
        check("wrap_instr0", instr_q[0], 32'h2152_FFFC);

        // Reset mid-stream with one buffered entry and one outstanding
        do_reset();
        imem_req_ready = 1'b1;
        repeat (2) cycle();
        check("mrst_pre_id_valid", 32'(id_valid), 32'd1);
        rst = 1'b1;
        cycle();
        check("mrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mrst_id_valid",  32'(id_valid),       32'd0);
        check("mrst_id_instr",  id_instr,            32'h0);
        check("mrst_id_pc",     id_pc,               32'h0);
        rst = 1'b0;
        #1;
        check("mrst_valid_after", 32'(imem_req_valid), 32'd1);
        check("mrst_addr_after",  imem_req_addr,       32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
